// File: rtl/mem_port_arbiter_pkg.sv
// Types shared by the unified memory port arbiter: FSM states, grant owner and bus command.
// No logic beyond a combinational round-robin pick.
package mem_port_arbiter_pkg;

  localparam int unsigned TIMER_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // On a tie the requester that did not win last time gets the port.
  function automatic arb_grant_t pick_grant(input logic       i_req,
                                            input logic       d_req,
                                            input arb_grant_t last);
    if (i_req && d_req) begin
      return (last == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      return GRANT_D;
    end
    return GRANT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Bus timeout counter: cleared on grant, counts busy cycles without ack.
// expired is combinational and fires in the TIMEOUT_CYC-th busy cycle; no backpressure.
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYC - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts the busy cycles already spent, so the current one is cnt_q+1.
  assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one memory port, round-robin on ties, with bus timeout.
// Grant to done is ack+1 cycles (min 2); requesters wait on stall_* until their done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        bus_err
);

  arb_state_t  state_q, state_d;
  arb_grant_t  last_grant_q, last_grant_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmr_clr, tmr_en, tmr_expired;
  arb_grant_t  grant;

  assign grant = pick_grant(i_req, d_req, last_grant_q);

  mem_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = grant;
          tmr_clr      = 1'b1;
          if (grant == GRANT_D) begin
            state_d = BUSY_D;
            cmd_d   = '{we: d_we, addr: d_addr, wdata: d_wdata};
          end else begin
            state_d = BUSY_I;
            cmd_d   = '{we: 1'b0, addr: i_addr, wdata: 32'd0};
          end
        end
      end
      BUSY_I, BUSY_D: begin
        tmr_en = !m_ack;
        // An ack in the final allowed cycle still counts as a clean completion.
        if (m_ack) begin
          rdata_d = m_rdata;
          state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
        end else if (tmr_expired) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
        end
      end
      DONE_I, DONE_D: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      cmd_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign m_valid = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign m_we    = cmd_q.we;
  assign m_addr  = cmd_q.addr;
  assign m_wdata = cmd_q.wdata;

  assign i_done  = (state_q == DONE_I);
  assign d_done  = (state_q == DONE_D);
  assign i_rdata = i_done ? rdata_q : 32'd0;
  assign d_rdata = d_done ? rdata_q : 32'd0;
  assign bus_err = (i_done || d_done) && err_q;

  assign stall_fetch = i_req && !i_done;
  assign stall_mem   = d_req && !d_done;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (lw/sw) of the five-stage pipeline. A request/acknowledge FSM serialises the two requesters with round-robin tie-breaking and enforces a bus timeout. It emits per-requester completion pulses and raw stall signals, which the hazard unit folds into its per-stage stall/flush vector.

## Interface
- TIMEOUT_CYC, 255: cycles in a busy state without m_ack before the transaction is aborted; range 1..65535.
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  32  fetch address (pc).
- i_rdata  out  32  instruction word; valid only while i_done=1.
- i_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store (sw), 0 = load (lw).
- d_addr  in  32  data address (alu_result).
- d_wdata  in  32  store data (rt_word).
- d_rdata  out  32  load data; valid only while d_done=1.
- d_done  out  1  one-cycle completion pulse for data.
- m_valid  out  1  bus transaction active.
- m_we, m_addr, m_wdata  out  1/32/32  bus command, stable while m_valid=1.
- m_ack  in  1  bus completion pulse; m_rdata valid in the same cycle.
- m_rdata  in  32  bus read data.
- stall_fetch  out  1  i_req && !i_done.
- stall_mem  out  1  d_req && !d_done.
- bus_err  out  1  one-cycle pulse, coincident with the done pulse of a timed-out transaction.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D. Reset state is IDLE.
- IDLE:
  - d_req only: go to BUSY_D.
  - i_req only: go to BUSY_I.
  - Both: grant the requester not granted last (last_grant register, reset value = fetch, so the first tie goes to data).
  - Neither: stay in IDLE.
- On grant, latch the command into internal registers: addr and we=0 for fetch; addr, we and wdata for data. Update last_grant.
- BUSY_x:
  - m_valid=1, with the bus command driven from the latched registers.
  - On m_ack: capture m_rdata into rdata_q, go to DONE_x.
  - On timer reaching TIMEOUT_CYC without m_ack: rdata_q=0, set err_q, go to DONE_x.
- DONE_x:
  - x_done=1 and x_rdata=rdata_q. bus_err=err_q. m_valid=0.
  - Clear err_q. Go to IDLE unconditionally.
- Requester contract: a requester drops or changes its req in the cycle after its done pulse, when the pipeline advances. Any req high in IDLE is treated as a new transaction.
- Stores also complete through m_ack; d_rdata is then don't-care, and the bench must not check it.
- A late m_ack (arriving in DONE or IDLE) is ignored.
- Timer: 16-bit. Cleared on entry to BUSY, increments each BUSY cycle without m_ack.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - m_valid, i_done, d_done and bus_err go to 0.
  - i_rdata, d_rdata, m_addr and m_wdata go to 0; m_we goes to 0.
  - last_grant resets to fetch. err_q and timer reset to 0.
  - Reset asserted mid-transaction drops m_valid in the same cycle. No done pulse is issued for the aborted transaction.
- Latency: req seen in IDLE at cycle 0 gives m_valid from cycle 1. m_ack at cycle k gives done at cycle k+1.
- Minimum latency (ack on the first busy cycle) is done at cycle 2, giving a 3-cycle occupancy per transaction.
- Back-to-back: after DONE_x there is one IDLE cycle, then the next grant.
- Timeout: with no ack, m_valid stays high for exactly TIMEOUT_CYC cycles, and done plus bus_err follow in the next cycle.
- stall_* are combinational from req and done. They fall in the done cycle itself.

## Structure
- Add to the shared pipes package:
  - arb_state_t enum (IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D).
  - arb_grant_t (GRANT_I, GRANT_D).
  - A mem_cmd_t packed struct (we, addr, wdata) used for the latched command.
- Sub-module mem_arb_timer: 16-bit cycle counter with clear, enable, TIMEOUT_CYC compare and expired output.
- Top-level total is roughly 150–220 lines.

## Test plan
- Fetch only:
  - Stimulus: i_req=1, i_addr=0x00000004; m_ack returned 3 cycles after m_valid rises, with m_rdata=0x8C080000.
  - Required response: i_done at ack+1 with i_rdata=0x8C080000; stall_fetch=1 until that cycle.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req rise together; d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF.
  - Required response: data is granted first, with m_we=1, m_addr=0x100, m_wdata=0xDEADBEEF. Fetch is granted only after DONE_D plus one IDLE cycle.
- Round-robin:
  - Stimulus: two consecutive ties.
  - Required response: the grant order is D, I, D, I.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4, d_req load with no m_ack.
  - Required response: m_valid high for 4 cycles, then d_done=1, d_rdata=0 and bus_err=1 for one cycle. A late m_ack afterwards produces no effect.
- Reset mid-transaction:
  - Stimulus: resetn goes low in BUSY_I.
  - Required response: m_valid drops to 0 immediately, with no i_done. After release, the next tie grants data.
- Minimum latency:
  - Stimulus: m_ack tied high.
  - Required response: a continuously re-issued fetch completes every 3 cycles.
